// File: rtl/z80_uart_fifo.sv
// z80_uart_fifo
//   I/O-mapped 8N1 UART for the Z80 bus with TX and RX FIFOs, a runtime baud
//   divisor (16x oversampling), internal loopback and a maskable interrupt.
//
// Ports
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   cs        chip select from the I/O window decode
//   rs[1:0]   register select: 0 DATA, 1 STATUS/CTRL, 2 DIV_LO, 3 DIV_HI
//   rd, wr    read / write strobe levels (acted on at their rising edge only)
//   data_in   CPU write data
//   data_out  read data, combinational from rs
//   irq_n     registered active-low interrupt request
//   txd       serial output, idle high
//   rxd       asynchronous serial input
module z80_uart_fifo #(
  parameter int unsigned c_fifo_log2   = 4,
  parameter logic [15:0] c_div_reset   = 16'd162,
  parameter int unsigned c_sync_stages = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic [1:0] rs,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned depth = 2 ** c_fifo_log2;
  localparam int unsigned aw    = c_fifo_log2;
  localparam int unsigned pw    = c_fifo_log2 + 1;
  localparam logic [pw-1:0] ptr_one    = pw'(1);
  localparam logic [pw-1:0] half_level = pw'(depth / 2);

  localparam logic [1:0] s_idle  = 2'd0;
  localparam logic [1:0] s_start = 2'd1;
  localparam logic [1:0] s_data  = 2'd2;
  localparam logic [1:0] s_stop  = 2'd3;

  // Bus strobe edge detection: a strobe held for many clocks acts once.
  logic rd_q, wr_q;
  logic rd_lvl, wr_lvl, rd_act, wr_act;
  logic data_wr, ctrl_wr, divlo_wr, divhi_wr, data_rd, stat_rd, flush;

  assign rd_lvl = cs & rd;
  assign wr_lvl = cs & wr;
  assign wr_act = wr_lvl & ~wr_q;
  // A read rising together with a write is ignored; the write wins.
  assign rd_act = rd_lvl & ~rd_q & ~wr_act;

  assign data_wr  = wr_act & (rs == 2'd0);
  assign ctrl_wr  = wr_act & (rs == 2'd1);
  assign divlo_wr = wr_act & (rs == 2'd2);
  assign divhi_wr = wr_act & (rs == 2'd3);
  assign data_rd  = rd_act & (rs == 2'd0);
  assign stat_rd  = rd_act & (rs == 2'd1);
  assign flush    = ctrl_wr & data_in[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd_lvl;
      wr_q <= wr_lvl;
    end
  end

  // Control and divisor registers; flush is a one-clock pulse, not stored.
  logic        rx_ie, txe_ie, loopback;
  logic [15:0] div;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ie    <= 1'b0;
      txe_ie   <= 1'b0;
      loopback <= 1'b0;
      div      <= c_div_reset;
    end else begin
      if (ctrl_wr) begin
        rx_ie    <= data_in[0];
        txe_ie   <= data_in[1];
        loopback <= data_in[2];
      end
      if (divlo_wr) div[7:0]  <= data_in;
      if (divhi_wr) div[15:8] <= data_in;
    end
  end

  // Oversampling tick: a new divisor only takes effect at the next reload.
  logic [15:0] baud_cnt;
  logic        tick;

  assign tick = (baud_cnt == 16'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  baud_cnt <= c_div_reset;
    else if (tick) baud_cnt <= div;
    else           baud_cnt <= baud_cnt - 16'd1;
  end

  // TX FIFO
  logic [7:0]    tx_mem [depth];
  logic [pw-1:0] tx_wptr, tx_rptr;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[aw] != tx_rptr[aw]) && (tx_wptr[aw-1:0] == tx_rptr[aw-1:0]);
  assign tx_push  = data_wr & ~tx_full;
  assign tx_head  = tx_mem[tx_rptr[aw-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[aw-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else if (flush) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + ptr_one;
      if (tx_pop)  tx_rptr <= tx_rptr + ptr_one;
    end
  end

  // TX FSM. The next byte is popped straight from STOP so frames run back to back.
  logic [1:0] tx_state;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_bcnt;
  logic [7:0] tx_shift;
  logic       tx_bit_done, tx_line, tx_idle;

  assign tx_bit_done = tick & (tx_tcnt == 4'd15);
  assign tx_pop = ~flush & ~tx_empty &
                  ((tx_state == s_idle) | ((tx_state == s_stop) & tx_bit_done));
  assign tx_idle = tx_empty & (tx_state == s_idle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= s_idle;
      tx_tcnt  <= 4'd0;
      tx_bcnt  <= 3'd0;
      tx_shift <= 8'd0;
    end else if (flush) begin
      tx_state <= s_idle;
      tx_tcnt  <= 4'd0;
      tx_bcnt  <= 3'd0;
    end else begin
      case (tx_state)
        s_idle: begin
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_tcnt  <= 4'd0;
            tx_state <= s_start;
          end
        end
        s_start: begin
          if (tick) tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_bit_done) begin
            tx_bcnt  <= 3'd0;
            tx_state <= s_data;
          end
        end
        s_data: begin
          if (tick) tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_bit_done) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bcnt  <= tx_bcnt + 3'd1;
            if (tx_bcnt == 3'd7) tx_state <= s_stop;
          end
        end
        default: begin
          if (tick) tx_tcnt <= tx_tcnt + 4'd1;
          if (tx_bit_done) begin
            if (tx_pop) begin
              tx_shift <= tx_head;
              tx_state <= s_start;
            end else begin
              tx_state <= s_idle;
            end
          end
        end
      endcase
    end
  end

  // Line level is decoded from reset-cleared state, so reset forces it high at once.
  assign tx_line = (tx_state == s_start) ? 1'b0 :
                   (tx_state == s_data)  ? tx_shift[0] : 1'b1;
  assign txd     = loopback ? 1'b1 : tx_line;

  // RX input synchroniser; loopback feeds the internal TX line instead of the pin.
  logic [c_sync_stages-1:0] sync_q;
  logic rx_src, rx_s, rx_prev;

  assign rx_src = loopback ? tx_line : rxd;
  assign rx_s   = sync_q[c_sync_stages-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[c_sync_stages-2:0], rx_src};
      rx_prev <= rx_s;
    end
  end

  // RX FIFO
  logic [7:0]    rx_mem [depth];
  logic [pw-1:0] rx_wptr, rx_rptr, rx_level;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_stop_done;
  logic [7:0]    rx_shift;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[aw] != rx_rptr[aw]) && (rx_wptr[aw-1:0] == rx_rptr[aw-1:0]);
  assign rx_level = rx_wptr - rx_rptr;
  assign rx_push  = rx_stop_done & ~rx_full;
  assign rx_pop   = data_rd & ~rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[aw-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else if (flush) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + ptr_one;
      if (rx_pop)  rx_rptr <= rx_rptr + ptr_one;
    end
  end

  // RX FSM. START checks the line again at its 8th tick to reject glitches;
  // later samples land 16 ticks apart, i.e. mid-bit.
  logic [1:0] rx_state;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bcnt;

  assign rx_stop_done = (rx_state == s_stop) & tick & (rx_tcnt == 4'd15);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= s_idle;
      rx_tcnt  <= 4'd0;
      rx_bcnt  <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      case (rx_state)
        s_idle: begin
          if (rx_prev & ~rx_s) begin
            rx_tcnt  <= 4'd0;
            rx_state <= s_start;
          end
        end
        s_start: begin
          if (tick) begin
            if (rx_tcnt == 4'd7) begin
              rx_tcnt <= 4'd0;
              rx_bcnt <= 3'd0;
              rx_state <= rx_s ? s_idle : s_data;
            end else begin
              rx_tcnt <= rx_tcnt + 4'd1;
            end
          end
        end
        s_data: begin
          if (tick) begin
            rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_tcnt == 4'd15) begin
              rx_shift <= {rx_s, rx_shift[7:1]};
              rx_bcnt  <= rx_bcnt + 3'd1;
              if (rx_bcnt == 3'd7) rx_state <= s_stop;
            end
          end
        end
        default: begin
          if (tick) begin
            rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_tcnt == 4'd15) rx_state <= s_idle;
          end
        end
      endcase
    end
  end

  // Sticky error flags: a new error in the same clock as the clearing read wins.
  logic fe, oe, fe_set, oe_set;

  assign fe_set = rx_stop_done & ~rx_s;
  assign oe_set = rx_stop_done & rx_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fe <= 1'b0;
      oe <= 1'b0;
    end else begin
      if (fe_set)       fe <= 1'b1;
      else if (stat_rd) fe <= 1'b0;
      if (oe_set)       oe <= 1'b1;
      else if (stat_rd) oe <= 1'b0;
    end
  end

  // Interrupt
  logic irq_cond;

  assign irq_cond = (rx_ie & ~rx_empty) | (txe_ie & tx_empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_n <= 1'b1;
    else          irq_n <= ~irq_cond;
  end

  // Read mux
  logic [7:0] status;

  assign status = {irq_cond, 1'b0, (rx_level >= half_level), oe, fe,
                   tx_idle, ~tx_full, ~rx_empty};

  always_comb begin
    data_out = 8'h00;
    case (rs)
      2'd0:    data_out = rx_empty ? 8'h00 : rx_mem[rx_rptr[aw-1:0]];
      2'd1:    data_out = status;
      2'd2:    data_out = div[7:0];
      default: data_out = div[15:8];
    endcase
  end

endmodule

// File: tb/tb_z80_uart_fifo.sv
// tb_z80_uart_fifo
//   Directed bench for z80_uart_fifo: bus register access, TX bit timing,
//   loopback, RX interrupt timing, overrun, framing error, glitch rejection,
//   held-strobe single action, flush and asynchronous reset.
module tb_z80_uart_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs = 1'b0;
  logic [1:0] rs = 2'd0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       irq_n;
  logic       txd;
  logic       rxd = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_nempty = -1;
  int t_irq = -1;
  bit mon_en = 1'b0;

  z80_uart_fifo dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cs       (cs),
    .rs       (rs),
    .rd       (rd),
    .wr       (wr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq_n    (irq_n),
    .txd      (txd),
    .rxd      (rxd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the first clock with a non-empty RX FIFO (rs held at STATUS) and the first with irq_n low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (t_nempty < 0 && data_out[0] === 1'b1) t_nempty = cyc;
      if (t_irq < 0 && irq_n === 1'b0) t_irq = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    rs = a; data_in = d; cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    rs = a; cs = 1'b1; rd = 1'b1;
    #1 d = data_out;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    rs = a;
    #1 d = data_out;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic [9:0] t1_exp;
    int k;
    bit saw_low;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_irq_n", irq_n, 1);
    reset_n = 1'b1;
    peek(2'd1, v);
    checkOutput("rst_status", v, 8'h06);
    bus_read(2'd2, v);
    checkOutput("rst_div_lo", v, 8'hA2);
    bus_read(2'd3, v);
    checkOutput("rst_div_hi", v, 8'h00);

    // 1: div=0, transmit A5
    applyStimulus(2'd2, 8'h00);
    applyStimulus(2'd3, 8'h00);
    repeat (200) @(negedge clk);
    applyStimulus(2'd0, 8'hA5);
    k = 0;
    while (txd === 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t1_start_seen", txd, 0);
    t1_exp = 10'b1101001010;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t1_bit%0d", i), txd, t1_exp[i]);
      repeat (16) @(negedge clk);
    end
    peek(2'd1, v);
    checkOutput("t1_idle_status", v, 8'h06);

    // 2: loopback, two bytes
    applyStimulus(2'd1, 8'h04);
    applyStimulus(2'd0, 8'h3C);
    applyStimulus(2'd0, 8'hC3);
    saw_low = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    checkOutput("t2_txd_pin_high", saw_low, 0);
    peek(2'd1, v);
    checkOutput("t2_status", v, 8'h07);
    bus_read(2'd0, v);
    checkOutput("t2_rd0", v, 8'h3C);
    bus_read(2'd0, v);
    checkOutput("t2_rd1", v, 8'hC3);
    bus_read(2'd0, v);
    checkOutput("t2_rd_empty", v, 8'h00);
    applyStimulus(2'd1, 8'h00);

    // 3: RX interrupt timing
    applyStimulus(2'd1, 8'h01);
    repeat (2) @(negedge clk);
    checkOutput("t3_irq_idle", irq_n, 1);
    peek(2'd1, v);
    t_nempty = -1;
    t_irq = -1;
    mon_en = 1'b1;
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    checkOutput("t3_nempty_seen", (t_nempty >= 0), 1);
    checkOutput("t3_irq_latency", t_irq - t_nempty, 1);
    bus_read(2'd0, v);
    checkOutput("t3_rd", v, 8'h55);
    checkOutput("t3_irq_after_pop", irq_n, 0);
    @(negedge clk);
    checkOutput("t3_irq_cleared", irq_n, 1);
    applyStimulus(2'd1, 8'h00);

    // 4: overrun after 16 bytes
    for (int i = 0; i < 16; i++) send_frame(8'h30 + 8'(i), 1'b1);
    send_frame(8'hEE, 1'b1);
    peek(2'd1, v);
    checkOutput("t4_status_oe", v, 8'h37);
    bus_read(2'd1, v);
    checkOutput("t4_status_rd", v, 8'h37);
    peek(2'd1, v);
    checkOutput("t4_status_cleared", v, 8'h27);
    for (int i = 0; i < 16; i++) begin
      bus_read(2'd0, v);
      checkOutput($sformatf("t4_rd%0d", i), v, 8'h30 + 8'(i));
    end
    bus_read(2'd0, v);
    checkOutput("t4_rd_empty", v, 8'h00);

    // 5: framing error and glitch rejection
    send_frame(8'h81, 1'b0);
    peek(2'd1, v);
    checkOutput("t5_status_fe", v, 8'h0F);
    bus_read(2'd0, v);
    checkOutput("t5_rd", v, 8'h81);
    bus_read(2'd1, v);
    checkOutput("t5_status_rd", v, 8'h0E);
    peek(2'd1, v);
    checkOutput("t5_fe_cleared", v, 8'h06);
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    peek(2'd1, v);
    checkOutput("t5_glitch_no_byte", v, 8'h06);

    // 6: held write strobe, full TX FIFO, flush mid-byte
    applyStimulus(2'd2, 8'hFF);
    applyStimulus(2'd3, 8'hFF);
    for (int i = 0; i < 15; i++) applyStimulus(2'd0, 8'h01 + 8'(i));
    peek(2'd1, v);
    checkOutput("t6_status_14", v, 8'h02);
    @(negedge clk);
    rs = 2'd0; data_in = 8'hAA; cs = 1'b1; wr = 1'b1;
    repeat (50) @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    peek(2'd1, v);
    checkOutput("t6_held_single_push", v, 8'h02);
    applyStimulus(2'd0, 8'hBB);
    peek(2'd1, v);
    checkOutput("t6_status_full", v, 8'h00);
    applyStimulus(2'd0, 8'hCC);
    peek(2'd1, v);
    checkOutput("t6_full_drop", v, 8'h00);
    checkOutput("t6_txd_mid_byte", txd, 0);
    applyStimulus(2'd1, 8'h80);
    rs = 2'd1;
    #1;
    checkOutput("t6_flush_txd", txd, 1);
    checkOutput("t6_flush_status", data_out, 8'h06);

    // Asynchronous reset mid-frame
    applyStimulus(2'd0, 8'h5A);
    repeat (2) @(negedge clk);
    checkOutput("t7_txd_sending", txd, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("t7_reset_txd", txd, 1);
    checkOutput("t7_reset_irq_n", irq_n, 1);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd2, v);
    checkOutput("t7_div_lo", v, 8'hA2);
    peek(2'd1, v);
    checkOutput("t7_status", v, 8'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
